mmm_nlp_ctrl: RTL and testbench
===============================

# mmm_nlp_ctrl

- Sequencer for one Montgomery modular multiplication, u = a·b·2^-90 mod N.
- Drives a single shared, free-running, non-stallable 90×90 pipelined multiplier, mmm_nlp_90b, through three dependent products:
  - T = a·b
  - m = T·N' mod 2^90
  - m·N
- Then reduces (T + m·N) >> 90 with one conditional subtraction.
- Sits beside the multiplier in the modular-arithmetic top level. Accepts operands and returns results over valid/ready handshakes.

## Interface
Parameters:
- IDW, 90, operand/result width; R = 2^IDW
- ODW, 181, multiplier product width
- MUL_LAT, 4, cycles from operands on o_mul_a/o_mul_b to matching product on i_mul_res

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  reset, asynchronous, active-low
- i_valid  in  1  request valid
- o_ready  out  1  request accepted when i_valid & o_ready
- i_a, i_b  in  IDW  operands; precondition a, b < N
- i_n  in  IDW  modulus; precondition odd, N < 2^89
- i_nprime  in  IDW  N' = −N^-1 mod 2^90
- o_valid  out  1  result valid
- i_ready  in  1  result consumed when o_valid & i_ready
- o_res  out  IDW  Montgomery product, < N
- o_mul_a, o_mul_b  out  IDW  multiplier operands (registered)
- i_mul_res  in  ODW  multiplier product

## Operation
- States: IDLE → MUL_T → MUL_M → MUL_U → RED → DONE → IDLE.
- IDLE:
  - o_ready=1.
  - On accept, register a, b, N, N'; go to MUL_T.
- MUL_T / MUL_M / MUL_U:
  - Operands per state:
    - MUL_T: o_mul_a=a, o_mul_b=b.
    - MUL_M: o_mul_a=T[89:0], o_mul_b=N'.
    - MUL_U: o_mul_a=m, o_mul_b=N.
  - Operands are registered and held constant for the whole phase.
  - A phase counter runs 0..MUL_LAT. At count MUL_LAT, i_mul_res is captured and the FSM advances.
  - Captured values: T (181 b), m = low 90 bits, P = m·N (181 b).
- RED:
  - S = T + P, 181 bits, no overflow given the preconditions.
  - u = S[180:90].
  - o_res ← (u ≥ N) ? u − N : u. Register o_res; go to DONE.
- DONE:
  - o_valid=1; o_res held.
  - On i_ready, go to IDLE.
- Outside MUL_* states, o_mul_a and o_mul_b are 0.
- Preconditions are not checked. On violation the FSM timing is unchanged and o_res is unspecified.

## Timing
- Reset values: o_ready=1, o_valid=0, o_res=0, o_mul_a=0, o_mul_b=0, state IDLE, counter 0.
- Let the accept edge end cycle 0. Then:
  - MUL_T operands present in cycles 1..1+L, with T captured at end of 1+L.
  - MUL_M: cycles 2+L..2+2L.
  - MUL_U: cycles 3+2L..3+3L.
  - RED: cycle 4+3L.
  - o_valid first high in cycle 5+3L, which is 17 for L=4.
- o_ready is low from cycle 1 until the cycle after the result handshake.
- No back-to-back overlap: the earliest next accept is the cycle after o_valid & i_ready.
- Backpressure: o_valid and o_res stay stable while i_ready=0, for any duration.
- i_valid while busy is ignored; no inputs are sampled outside IDLE.
- Reset assertion mid-operation returns the FSM to IDLE immediately and sets all outputs to reset values. The in-flight result is discarded, and multiplier products still in flight are never captured.
- i_ready when o_valid=0 has no effect.

## Structure
- Shared package mmm_nlp_pkg holds:
  - state enum
  - IDW, ODW, MUL_LAT defaults
  - RED_SHIFT = 90
- Sub-module mmm_nlp_red: combinational 181-bit add, shift, compare and conditional subtract. It is instantiated once and registered by the controller.
- The multiplier is not instantiated here; the top level wires the o_mul_*/i_mul_res ports to mmm_nlp_90b.

## Test plan
- N=13, N' from the bench model, a=3, b=5 → o_res=11; o_valid exactly 17 cycles after accept (MUL_LAT=4).
- N=13: a=1, b=1 → 12; a=12, b=12 → 12; a=0, b=7 → 0. Issued back-to-back with i_ready tied 1; each accept occurs the cycle after the previous result handshake.
- Random odd N < 2^89 and random a, b < N (≥1000 ops) vs the reference model. Include cases forcing u ≥ N, so the subtract path is covered.
- Hold i_ready=0 for 10 cycles in DONE → o_valid=1 and o_res constant throughout; o_ready=0; i_valid pulses ignored.
- Assert i_rstn=0 in cycle 8 of an operation → all outputs 0 and o_ready=1 after release. The next operation (a=3, b=5, N=13) returns 11 with nominal latency.
- Monitor o_mul_a/o_mul_b: each phase holds constant values for MUL_LAT+1 cycles, and values are 0 in IDLE/RED/DONE.

Source files
------------

// File: rtl/mmm_nlp_pkg.sv
// Shared definitions for the Montgomery multiplication sequencer.
package mmm_nlp_pkg;

    localparam int IDW_DEF     = 90;   // operand / result width, R = 2^IDW
    localparam int ODW_DEF     = 181;  // multiplier product width
    localparam int MUL_LAT_DEF = 4;    // multiplier pipeline latency in cycles
    localparam int RED_SHIFT   = 90;   // right shift applied to T + m*N

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL_T = 3'd1,
        ST_MUL_M = 3'd2,
        ST_MUL_U = 3'd3,
        ST_RED   = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/mmm_nlp_red.sv
// Final Montgomery reduction step: u = (T + m*N) >> SHIFT, then one
// conditional subtraction of N. Purely combinational; the controller
// registers the result.
module mmm_nlp_red
    import mmm_nlp_pkg::*;
#(
    parameter int IDW   = IDW_DEF,
    parameter int ODW   = ODW_DEF,
    parameter int SHIFT = RED_SHIFT
) (
    input  logic [ODW-1:0] i_t,
    input  logic [ODW-1:0] i_p,
    input  logic [IDW-1:0] i_n,
    output logic [IDW-1:0] o_u
);

    // u needs one bit above IDW because T + m*N < 2*N*R before the shift
    localparam int UW = ODW - SHIFT;

    logic [ODW-1:0] sum_s;
    logic [UW-1:0]  u_s;
    logic [UW-1:0]  n_ext_s;
    logic           ge_s;

    // Add, shift, compare and conditionally subtract the modulus
    always_comb begin
        sum_s   = i_t + i_p;
        u_s     = UW'(sum_s >> SHIFT);
        n_ext_s = UW'(i_n);
        ge_s    = (u_s >= n_ext_s);
        if (ge_s) begin
            o_u = IDW'(u_s - n_ext_s);
        end else begin
            o_u = IDW'(u_s);
        end
    end

endmodule

// File: rtl/mmm_nlp_ctrl.sv
// Sequencer for one Montgomery multiplication u = a*b*R^-1 mod N using a
// shared free-running pipelined multiplier: T = a*b, m = T*N' mod R,
// P = m*N, then u = (T + P) >> IDW with one conditional subtract.
module mmm_nlp_ctrl
    import mmm_nlp_pkg::*;
#(
    parameter int IDW     = IDW_DEF,
    parameter int ODW     = ODW_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic [IDW-1:0] i_a,
    input  logic [IDW-1:0] i_b,
    input  logic [IDW-1:0] i_n,
    input  logic [IDW-1:0] i_nprime,
    output logic           o_valid,
    input  logic           i_ready,
    output logic [IDW-1:0] o_res,
    output logic [IDW-1:0] o_mul_a,
    output logic [IDW-1:0] o_mul_b,
    input  logic [ODW-1:0] i_mul_res
);

    localparam int             CNT_W    = $clog2(MUL_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDW-1:0]   n_q, n_d;
    logic [IDW-1:0]   np_q, np_d;
    logic [ODW-1:0]   t_q, t_d;
    logic [ODW-1:0]   p_q, p_d;
    logic [IDW-1:0]   res_q, res_d;
    logic [IDW-1:0]   mul_a_q, mul_a_d;
    logic [IDW-1:0]   mul_b_q, mul_b_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic [IDW-1:0]   red_u_s;

    mmm_nlp_red #(
        .IDW   (IDW),
        .ODW   (ODW),
        .SHIFT (IDW)
    ) u_red (
        .i_t (t_q),
        .i_p (p_q),
        .i_n (n_q),
        .o_u (red_u_s)
    );

    // Next-state, phase counter, product capture and multiplier operand selection
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        np_d    = np_q;
        t_d     = t_q;
        p_d     = p_q;
        res_d   = res_q;
        mul_a_d = {IDW{1'b0}};
        mul_b_d = {IDW{1'b0}};

        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    n_d     = i_n;
                    np_d    = i_nprime;
                    cnt_d   = CNT_ZERO;
                    mul_a_d = i_a;
                    mul_b_d = i_b;
                    state_d = ST_MUL_T;
                end else begin
                    cnt_d = CNT_ZERO;
                end
            end
            ST_MUL_T: begin
                if (cnt_q == CNT_LAST) begin
                    // product of a*b arrives now; its low half feeds the m phase
                    t_d     = i_mul_res;
                    cnt_d   = CNT_ZERO;
                    mul_a_d = i_mul_res[IDW-1:0];
                    mul_b_d = np_q;
                    state_d = ST_MUL_M;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    mul_a_d = mul_a_q;
                    mul_b_d = mul_b_q;
                end
            end
            ST_MUL_M: begin
                if (cnt_q == CNT_LAST) begin
                    // m = T*N' mod R is the low half of the product
                    cnt_d   = CNT_ZERO;
                    mul_a_d = i_mul_res[IDW-1:0];
                    mul_b_d = n_q;
                    state_d = ST_MUL_U;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    mul_a_d = mul_a_q;
                    mul_b_d = mul_b_q;
                end
            end
            ST_MUL_U: begin
                if (cnt_q == CNT_LAST) begin
                    p_d     = i_mul_res;
                    cnt_d   = CNT_ZERO;
                    state_d = ST_RED;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    mul_a_d = mul_a_q;
                    mul_b_d = mul_b_q;
                end
            end
            ST_RED: begin
                res_d   = red_u_s;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                cnt_d   = CNT_ZERO;
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        valid_d = (state_d == ST_DONE);
    end

    // State, datapath and registered output flops
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            n_q     <= {IDW{1'b0}};
            np_q    <= {IDW{1'b0}};
            t_q     <= {ODW{1'b0}};
            p_q     <= {ODW{1'b0}};
            res_q   <= {IDW{1'b0}};
            mul_a_q <= {IDW{1'b0}};
            mul_b_q <= {IDW{1'b0}};
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            np_q    <= np_d;
            t_q     <= t_d;
            p_q     <= p_d;
            res_q   <= res_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_res   = res_q;
    assign o_mul_a = mul_a_q;
    assign o_mul_b = mul_b_q;

endmodule

// File: tb/tb_mmm_nlp_ctrl.sv
// Directed and random bench for mmm_nlp_ctrl with a behavioural 4-stage
// pipelined multiplier standing in for mmm_nlp_90b.
module tb_mmm_nlp_ctrl;

    localparam int IDW = 90;
    localparam int ODW = 181;
    localparam int L   = 4;

    logic           clk;
    logic           rstn;
    logic           i_valid;
    logic           o_ready;
    logic [IDW-1:0] i_a, i_b, i_n, i_nprime;
    logic           o_valid;
    logic           i_ready;
    logic [IDW-1:0] o_res;
    logic [IDW-1:0] o_mul_a, o_mul_b;
    logic [ODW-1:0] mul_res;

    int checks;
    int errors;

    mmm_nlp_ctrl #(.IDW(IDW), .ODW(ODW), .MUL_LAT(L)) dut (
        .i_clk     (clk),
        .i_rstn    (rstn),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_a       (i_a),
        .i_b       (i_b),
        .i_n       (i_n),
        .i_nprime  (i_nprime),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_res     (o_res),
        .o_mul_a   (o_mul_a),
        .o_mul_b   (o_mul_b),
        .i_mul_res (mul_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running multiplier model: product appears L cycles after operands
    logic [ODW-1:0] pipe [0:L-1];
    always @(posedge clk) begin
        pipe[0] <= ODW'(o_mul_a) * ODW'(o_mul_b);
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign mul_res = pipe[L-1];

    // N' = -N^-1 mod 2^90 by Newton iteration (precision doubles each step)
    function automatic logic [89:0] calc_nprime(input logic [89:0] n);
        logic [89:0] x;
        x = n;
        for (int k = 0; k < 7; k++) x = x * (90'd2 - n * x);
        return 90'd0 - x;
    endfunction

    // Reference a*b*2^-90 mod N: reduce a*b, then halve mod N ninety times
    function automatic logic [89:0] ref_mont(input logic [89:0] a, input logic [89:0] b,
                                             input logic [89:0] n);
        logic [179:0] prod;
        logic [179:0] r;
        logic [90:0]  x;
        prod = {90'd0, a} * {90'd0, b};
        r    = prod % {90'd0, n};
        x    = r[90:0];
        for (int k = 0; k < 90; k++) begin
            if (x[0]) x = (x + {1'b0, n}) >> 1;
            else      x = x >> 1;
        end
        return x[89:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation with i_ready=1, exact latency and operand-bus checks
    task automatic run_op(input logic [89:0] a, input logic [89:0] b,
                          input logic [89:0] n, input logic [89:0] expv,
                          input string tag);
        logic [89:0]  np, tl, mm, ea, eb;
        logic [179:0] prod;
        np   = calc_nprime(n);
        prod = {90'd0, a} * {90'd0, b};
        tl   = prod[89:0];
        mm   = tl * np;
        i_ready = 1'b1;
        checks++;
        if (o_ready !== 1'b1) begin
            errors++; $display("FAIL %s ready_before_accept: got %0b exp 1", tag, o_ready);
        end
        i_valid = 1'b1; i_a = a; i_b = b; i_n = n; i_nprime = np;
        tick();
        i_valid = 1'b0; i_a = '0; i_b = '0;
        for (int c = 1; c <= 16; c++) begin
            if (c <= 5)       begin ea = a;     eb = b;     end
            else if (c <= 10) begin ea = tl;    eb = np;    end
            else if (c <= 15) begin ea = mm;    eb = n;     end
            else              begin ea = 90'd0; eb = 90'd0; end
            checks++;
            if (o_valid !== 1'b0 || o_ready !== 1'b0) begin
                errors++; $display("FAIL %s busy_flags cyc %0d: got valid=%0b ready=%0b exp 0/0",
                                   tag, c, o_valid, o_ready);
            end
            checks++;
            if (o_mul_a !== ea || o_mul_b !== eb) begin
                errors++; $display("FAIL %s mul_operands cyc %0d: got %0h/%0h exp %0h/%0h",
                                   tag, c, o_mul_a, o_mul_b, ea, eb);
            end
            tick();
        end
        checks++;
        if (o_valid !== 1'b1) begin
            errors++; $display("FAIL %s latency: o_valid=%0b at cycle 17 exp 1", tag, o_valid);
        end
        checks++;
        if (o_res !== expv) begin
            errors++; $display("FAIL %s result: got %0h exp %0h (a=%0h b=%0h n=%0h)",
                               tag, o_res, expv, a, b, n);
        end
        checks++;
        if (o_mul_a !== 90'd0 || o_mul_b !== 90'd0) begin
            errors++; $display("FAIL %s mul_done_zero: got %0h/%0h exp 0/0", tag, o_mul_a, o_mul_b);
        end
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            errors++; $display("FAIL %s after_handshake: got valid=%0b ready=%0b exp 0/1",
                               tag, o_valid, o_ready);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_a = '0; i_b = '0; i_n = '0; i_nprime = '0;
        #12;
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_res !== 90'd0 ||
            o_mul_a !== 90'd0 || o_mul_b !== 90'd0) begin
            errors++; $display("FAIL reset_values: got rdy=%0b vld=%0b res=%0h ma=%0h mb=%0h exp 1/0/0/0/0",
                               o_ready, o_valid, o_res, o_mul_a, o_mul_b);
        end
        rstn = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_basic();
        run_op(90'd3, 90'd5, 90'd13, 90'd11, "basic_3x5");
    endtask

    task automatic test_back_to_back();
        run_op(90'd1,  90'd1,  90'd13, 90'd12, "b2b_1x1");
        run_op(90'd12, 90'd12, 90'd13, 90'd12, "b2b_12x12");
        run_op(90'd0,  90'd7,  90'd13, 90'd0,  "b2b_0x7");
    endtask

    task automatic test_random();
        logic [95:0] r;
        logic [89:0] n, a, b;
        for (int k = 0; k < 1000; k++) begin
            r = {$urandom, $urandom, $urandom};
            n = {1'b0, r[88:0]};
            n[0] = 1'b1;
            if (k % 2 == 0) n[88] = 1'b1;
            if (n < 90'd3) n = 90'd3;
            r = {$urandom, $urandom, $urandom};
            a = 90'(r % {6'd0, n});
            r = {$urandom, $urandom, $urandom};
            b = 90'(r % {6'd0, n});
            if (k % 10 == 0) begin a = n - 90'd1; b = n - 90'd1; end
            if (k % 10 == 5) begin a = n - 90'd1; b = n - 90'd2; end
            run_op(a, b, n, ref_mont(a, b, n), "random");
        end
    endtask

    task automatic test_backpressure();
        i_ready = 1'b0;
        i_valid = 1'b1; i_a = 90'd12; i_b = 90'd12; i_n = 90'd13; i_nprime = calc_nprime(90'd13);
        tick();
        i_valid = 1'b0;
        repeat (16) tick();
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (o_valid !== 1'b1 || o_res !== 90'd12 || o_ready !== 1'b0) begin
                errors++; $display("FAIL backpressure_hold cyc %0d: got vld=%0b res=%0h rdy=%0b exp 1/c/0",
                                   c, o_valid, o_res, o_ready);
            end
            i_valid = c[0]; i_a = 90'd3; i_b = 90'd5;
            tick();
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_res !== 90'd12) begin
            errors++; $display("FAIL backpressure_release: got vld=%0b rdy=%0b res=%0h exp 0/1/c",
                               o_valid, o_ready, o_res);
        end
        tick();
        checks++;
        if (o_ready !== 1'b1 || o_mul_a !== 90'd0) begin
            errors++; $display("FAIL busy_pulse_ignored: got rdy=%0b ma=%0h exp 1/0", o_ready, o_mul_a);
        end
    endtask

    task automatic test_mid_reset();
        i_ready = 1'b1;
        i_valid = 1'b1; i_a = 90'd3; i_b = 90'd5; i_n = 90'd13; i_nprime = calc_nprime(90'd13);
        tick();
        i_valid = 1'b0;
        repeat (7) tick();
        rstn = 1'b0;
        #1;
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_res !== 90'd0 ||
            o_mul_a !== 90'd0 || o_mul_b !== 90'd0) begin
            errors++; $display("FAIL mid_reset_outputs: got rdy=%0b vld=%0b res=%0h ma=%0h mb=%0h exp 1/0/0/0/0",
                               o_ready, o_valid, o_res, o_mul_a, o_mul_b);
        end
        #1;
        rstn = 1'b1;
        tick();
        for (int c = 0; c < 12; c++) begin
            checks++;
            if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_res !== 90'd0) begin
                errors++; $display("FAIL post_reset_idle cyc %0d: got rdy=%0b vld=%0b res=%0h exp 1/0/0",
                                   c, o_ready, o_valid, o_res);
            end
            tick();
        end
        run_op(90'd3, 90'd5, 90'd13, 90'd11, "after_reset");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
